decoding_stage: RTL

- Decompression-side counterpart of the compressor matching stage. Accepts up to two decoded tokens per cycle (pattern code, dictionary location, literal payload), rebuilds the original 32-bit words into one 64-bit output, and keeps a 16-entry FIFO dictionary in lockstep with the compressor's.
- Sits between the bitstream unpacker and the output word buffer.

---
 rtl/decoding_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/decoding_stage.sv
// Dictionary decompressor stage: rebuilds up to two 32-bit words per cycle from decoded tokens
// and keeps a 16-entry FIFO dictionary in lockstep with the compressor.
module decoding_stage #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DICT_ENTRY = 16,
  parameter int unsigned DICT_WORD  = 32,
  parameter int unsigned WORD       = 32
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic                              i_pair,
  input  logic [2:0]                        i_code1,
  input  logic [$clog2(DICT_ENTRY)-1:0]     i_location1,
  input  logic [WORD-1:0]                   i_payload1,
  input  logic [2:0]                        i_code2,
  input  logic [$clog2(DICT_ENTRY)-1:0]     i_location2,
  input  logic [WORD-1:0]                   i_payload2,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [WIDTH-1:0]                  o_word,
  output logic [1:0]                        o_word_mask,
  output logic [5:0]                        o_length1,
  output logic [5:0]                        o_length2,
  output logic                              o_dict_full,
  output logic                              o_error,
  output logic [DICT_ENTRY*DICT_WORD-1:0]   dictionary_data
);

  localparam int unsigned PtrW = $clog2(DICT_ENTRY);

  typedef struct packed {
    logic [WORD-1:0] word;
    logic [5:0]      len;
    logic            push;
    logic            illegal;
  } dec_t;

  function automatic dec_t decode(input logic [2:0] code, input logic [DICT_WORD-1:0] d,
                                  input logic [WORD-1:0] p);
    dec_t r;
    r = '0;
    unique case (code)
      3'b000: r.len = 6'd2;
      3'b001: begin r.word = d;                       r.len = 6'd6; end
      3'b010: begin r.word = {d[31:8], p[7:0]};       r.len = 6'd16; r.push = 1'b1; end
      3'b011: begin r.word = {d[31:16], p[15:0]};     r.len = 6'd24; r.push = 1'b1; end
      3'b100: begin r.word = {24'h0, p[7:0]};         r.len = 6'd12; end
      3'b101: begin r.word = p;                       r.len = 6'd34; r.push = 1'b1; end
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  logic [DICT_WORD-1:0] r_dict [DICT_ENTRY];
  logic [PtrW-1:0]      r_ptr;
  logic                 r_valid, r_full, r_error;
  logic [WIDTH-1:0]     r_word;
  logic [1:0]           r_mask;
  logic [5:0]           r_len1, r_len2;

  dec_t                 w_dec1, w_dec2;
  logic [DICT_WORD-1:0] w_d2;
  logic [PtrW-1:0]      w_slot2;
  logic [PtrW:0]        w_ptr_sum;
  logic                 w_push2, w_xfer, w_illegal;

  assign o_ready = !r_valid || i_ready;
  assign w_xfer  = i_valid && o_ready;

  always_comb begin
    w_dec1  = decode(i_code1, r_dict[i_location1], i_payload1);
    w_slot2 = r_ptr + {{(PtrW-1){1'b0}}, w_dec1.push};
    // Token2 sees token1's push: forward word1 when it targets the slot just written.
    w_d2    = (w_dec1.push && (i_location2 == r_ptr)) ? w_dec1.word : r_dict[i_location2];
    w_dec2  = decode(i_code2, w_d2, i_payload2);
    w_push2 = i_pair && w_dec2.push;
    w_ptr_sum = {1'b0, r_ptr} + {{PtrW{1'b0}}, w_dec1.push} + {{PtrW{1'b0}}, w_push2};
    w_illegal = w_dec1.illegal || (i_pair && w_dec2.illegal);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < DICT_ENTRY; k++) r_dict[k] <= '0;
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (w_xfer) begin
      if (w_dec1.push) r_dict[r_ptr] <= w_dec1.word;
      if (w_push2)     r_dict[w_slot2] <= w_dec2.word;
      r_ptr <= w_ptr_sum[PtrW-1:0];
      if (w_ptr_sum[PtrW]) r_full <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_valid <= 1'b0;
      r_word  <= '0;
      r_mask  <= '0;
      r_len1  <= '0;
      r_len2  <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_word  <= {(i_pair ? w_dec2.word : {WORD{1'b0}}), w_dec1.word};
        r_mask  <= {i_pair, 1'b1};
        r_len1  <= w_dec1.len;
        r_len2  <= i_pair ? w_dec2.len : 6'd0;
        if (w_illegal) r_error <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    dictionary_data = '0;
    for (int k = 0; k < DICT_ENTRY; k++) dictionary_data[k*DICT_WORD +: DICT_WORD] = r_dict[k];
  end

  assign o_valid     = r_valid;
  assign o_word      = r_word;
  assign o_word_mask = r_mask;
  assign o_length1   = r_len1;
  assign o_length2   = r_len2;
  assign o_dict_full = r_full;
  assign o_error     = r_error;

endmodule
